// File: rtl/sb_pkg.sv
// Shared definitions for the instruction-prefetch stream buffer and its memory adapter.
// The line geometry helpers are reused by the stream buffer itself.
package sb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } sb_mem_state_e;

  // Number of memory beats that make up one cache line.
  function automatic int sb_nbeats(input int cl_size, input int data_width);
    return cl_size / data_width;
  endfunction

  // Byte-offset bits inside one cache line.
  function automatic int sb_offs(input int cl_size);
    return $clog2(cl_size / 8);
  endfunction

  localparam int SB_DEF_DATA_WIDTH = 32;
  localparam int SB_DEF_ADDR_WIDTH = 32;
  localparam int SB_DEF_CL_SIZE    = 64;
  localparam int SB_DEF_NBEATS     = SB_DEF_CL_SIZE / SB_DEF_DATA_WIDTH;
  localparam int SB_DEF_OFFS       = $clog2(SB_DEF_CL_SIZE / 8);

endpackage

// File: rtl/sb_mem_adapter_if.sv
// Bundle of the stream-buffer side and memory side signals of sb_mem_adapter.
// master = the adapter's view, slave = the stream buffer / memory environment.
interface sb_mem_adapter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CL_SIZE    = 64
) ();
  logic                  flush;
  logic                  en;
  logic                  sb_req;
  logic [ADDR_WIDTH-1:0] sb_addr;
  logic [CL_SIZE-1:0]    sb_data;
  logic                  sb_done;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  busy;

  modport master (
    input  flush, en, sb_req, sb_addr, mem_gnt, mem_rvalid, mem_rdata,
    output sb_data, sb_done, mem_req, mem_addr, busy
  );

  modport slave (
    output flush, en, sb_req, sb_addr, mem_gnt, mem_rvalid, mem_rdata,
    input  sb_data, sb_done, mem_req, mem_addr, busy
  );
endinterface

// File: rtl/sb_mem_adapter.sv
// Turns a level-style stream-buffer line request into one line-aligned memory read,
// assembles the multi-beat response and returns it with a one-cycle done pulse.
module sb_mem_adapter
  import sb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CL_SIZE    = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  en_i,
  input  logic                  sb_req_i,
  input  logic [ADDR_WIDTH-1:0] sb_addr_i,
  output logic [CL_SIZE-1:0]    sb_data_o,
  output logic                  sb_done_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o
);

  localparam int NBEATS = sb_nbeats(CL_SIZE, DATA_WIDTH);
  localparam int OFFS   = sb_offs(CL_SIZE);
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(NBEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

  sb_mem_state_e         state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  abort_q, abort_d;
  logic                  just_done_q, just_done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CL_SIZE-1:0]    line_q, line_d;

  logic last_beat;
  assign last_beat = (cnt_q == LAST_BEAT);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    just_done_d = 1'b0;
    addr_d      = addr_q;
    line_d      = line_q;

    case (state_q)
      IDLE: begin
        // just_done_q masks the stream buffer's request that is still high
        // in the cycle right after delivery.
        if (en_i && sb_req_i && !flush_i && !just_done_q) begin
          addr_d  = sb_addr_i & ALIGN_MASK;
          state_d = REQ;
        end
      end

      REQ: begin
        // The request stays up after a flush so the handshake is never retracted.
        if (flush_i) begin
          abort_d = 1'b1;
        end
        if (mem_gnt_i) begin
          cnt_d   = '0;
          state_d = (abort_q || flush_i) ? DRAIN : RESP;
        end
      end

      RESP: begin
        if (flush_i) begin
          abort_d = 1'b1;
          state_d = DRAIN;
          if (mem_rvalid_i) begin
            if (last_beat) begin
              abort_d = 1'b0;
              cnt_d   = '0;
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end else if (mem_rvalid_i) begin
          line_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = mem_rdata_i;
          if (last_beat) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        just_done_d = 1'b1;
        state_d     = IDLE;
      end

      DRAIN: begin
        if (mem_rvalid_i) begin
          if (last_beat) begin
            abort_d = 1'b0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      just_done_q <= 1'b0;
      addr_q      <= '0;
      line_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      just_done_q <= just_done_d;
      addr_q      <= addr_d;
      line_q      <= line_d;
    end
  end

  // Outputs come straight from flops or a state decode; nothing is combinational from inputs.
  assign mem_req_o  = (state_q == REQ);
  assign mem_addr_o = addr_q;
  assign sb_done_o  = (state_q == DONE);
  assign sb_data_o  = line_q;
  assign busy_o     = (state_q != IDLE);

endmodule
